// File: rtl/morse_transmitter.sv
// -----------------------------------------------------------------------------
// morse_transmitter
//   Serialises one ASCII character at a time into an ITU Morse bit stream.
//   A dot is 1,0; a dash is 1,1,1,0; letters and digits end with two extra 0s;
//   space is 0,0,0,0. Each bit is held BIT_CYCLES clock cycles.
//
//   Optional build macro: MORSE_TX_LOWERCASE_EN
//     defined   -> a-z are encoded like A-Z
//     undefined -> a-z are rejected as unsupported (o_err pulse)
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      character offered on i_char
//   i_char       ASCII character (8 bits)
//   o_ready      high in IDLE; a character is taken when i_valid & o_ready
//   o_data_morse registered serial Morse bit
//   o_done       one-cycle pulse in the final cycle of a symbol
//   o_err        one-cycle pulse after an unsupported character is rejected
// -----------------------------------------------------------------------------
module morse_transmitter #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_char,
    output logic       o_ready,
    output logic       o_data_morse,
    output logic       o_done,
    output logic       o_err
);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, TERM} state_t;

    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);
    localparam logic [7:0] PEN_CYC  = (BIT_CYCLES > 1) ? 8'(BIT_CYCLES - 2) : 8'd0;

    state_t     state;
    logic [7:0] cyc_cnt;    // cycles elapsed in the current bit
    logic [2:0] elem_cnt;   // elements still to send after the current one
    logic [2:0] bit_left;   // bits still to send in the current state after this one
    logic [4:0] pat;        // remaining pattern, current element in bit 4 (1 = dash)

    // ---------------------------------------------------------------- lookup
    logic [7:0] ch_norm;
    logic [8:0] lut;        // {supported, element count, pattern (first element at MSB of used field)}
    logic       lut_ok;
    logic [2:0] lut_cnt;
    logic [4:0] lut_pat;
    logic [4:0] pat_aligned;
    logic       is_space;

    always_comb begin
`ifdef MORSE_TX_LOWERCASE_EN
        ch_norm = (i_char >= 8'h61 && i_char <= 8'h7A) ? (i_char - 8'h20) : i_char;
`else
        ch_norm = i_char;
`endif
    end

    always_comb begin
        lut = 9'h000;
        case (ch_norm)
            8'h41: lut = {1'b1, 3'd2, 5'b00001};  // A .-
            8'h42: lut = {1'b1, 3'd4, 5'b01000};  // B -...
            8'h43: lut = {1'b1, 3'd4, 5'b01010};  // C -.-.
            8'h44: lut = {1'b1, 3'd3, 5'b00100};  // D -..
            8'h45: lut = {1'b1, 3'd1, 5'b00000};  // E .
            8'h46: lut = {1'b1, 3'd4, 5'b00010};  // F ..-.
            8'h47: lut = {1'b1, 3'd3, 5'b00110};  // G --.
            8'h48: lut = {1'b1, 3'd4, 5'b00000};  // H ....
            8'h49: lut = {1'b1, 3'd2, 5'b00000};  // I ..
            8'h4A: lut = {1'b1, 3'd4, 5'b00111};  // J .---
            8'h4B: lut = {1'b1, 3'd3, 5'b00101};  // K -.-
            8'h4C: lut = {1'b1, 3'd4, 5'b00100};  // L .-..
            8'h4D: lut = {1'b1, 3'd2, 5'b00011};  // M --
            8'h4E: lut = {1'b1, 3'd2, 5'b00010};  // N -.
            8'h4F: lut = {1'b1, 3'd3, 5'b00111};  // O ---
            8'h50: lut = {1'b1, 3'd4, 5'b00110};  // P .--.
            8'h51: lut = {1'b1, 3'd4, 5'b01101};  // Q --.-
            8'h52: lut = {1'b1, 3'd3, 5'b00010};  // R .-.
            8'h53: lut = {1'b1, 3'd3, 5'b00000};  // S ...
            8'h54: lut = {1'b1, 3'd1, 5'b00001};  // T -
            8'h55: lut = {1'b1, 3'd3, 5'b00001};  // U ..-
            8'h56: lut = {1'b1, 3'd4, 5'b00001};  // V ...-
            8'h57: lut = {1'b1, 3'd3, 5'b00011};  // W .--
            8'h58: lut = {1'b1, 3'd4, 5'b01001};  // X -..-
            8'h59: lut = {1'b1, 3'd4, 5'b01011};  // Y -.--
            8'h5A: lut = {1'b1, 3'd4, 5'b01100};  // Z --..
            8'h30: lut = {1'b1, 3'd5, 5'b11111};  // 0 -----
            8'h31: lut = {1'b1, 3'd5, 5'b01111};  // 1 .----
            8'h32: lut = {1'b1, 3'd5, 5'b00111};  // 2 ..---
            8'h33: lut = {1'b1, 3'd5, 5'b00011};  // 3 ...--
            8'h34: lut = {1'b1, 3'd5, 5'b00001};  // 4 ....-
            8'h35: lut = {1'b1, 3'd5, 5'b00000};  // 5 .....
            8'h36: lut = {1'b1, 3'd5, 5'b10000};  // 6 -....
            8'h37: lut = {1'b1, 3'd5, 5'b11000};  // 7 --...
            8'h38: lut = {1'b1, 3'd5, 5'b11100};  // 8 ---..
            8'h39: lut = {1'b1, 3'd5, 5'b11110};  // 9 ----.
            default: lut = 9'h000;
        endcase
    end

    assign lut_ok      = lut[8];
    assign lut_cnt     = lut[7:5];
    assign lut_pat     = lut[4:0];
    // left-justify so the element being sent is always pat[4]
    assign pat_aligned = 5'(lut_pat << (3'd5 - lut_cnt));
    assign is_space    = (i_char == 8'h20);

    // ---------------------------------------------------------------- control
    logic last_cyc;
    logic term_fin;

    assign last_cyc = (cyc_cnt == LAST_CYC);
    // The final 0 of every symbol spends its last cycle in IDLE (output is 0
    // there anyway), so o_ready rises in time for the next character to start
    // on the very next edge with no gap bit. TERM therefore leaves one cycle early.
    assign term_fin = (BIT_CYCLES == 1) ? (bit_left == 3'd1)
                                        : (bit_left == 3'd0 && cyc_cnt == PEN_CYC);

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_data_morse <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
            cyc_cnt      <= 8'd0;
            elem_cnt     <= 3'd0;
            bit_left     <= 3'd0;
            pat          <= 5'd0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    o_data_morse <= 1'b0;
                    cyc_cnt      <= 8'd0;
                    if (i_valid) begin
                        if (is_space) begin
                            state    <= TERM;
                            bit_left <= 3'd3;
                        end else if (lut_ok) begin
                            state        <= MARK;
                            o_data_morse <= 1'b1;
                            pat          <= pat_aligned;
                            elem_cnt     <= lut_cnt - 3'd1;
                            bit_left     <= pat_aligned[4] ? 3'd2 : 3'd0;
                        end else begin
                            o_err <= 1'b1;
                        end
                    end
                end
                MARK: begin
                    if (last_cyc) begin
                        cyc_cnt <= 8'd0;
                        if (bit_left == 3'd0) begin
                            state        <= SPACE;
                            o_data_morse <= 1'b0;
                        end else begin
                            bit_left <= bit_left - 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                SPACE: begin
                    if (last_cyc) begin
                        cyc_cnt <= 8'd0;
                        if (elem_cnt != 3'd0) begin
                            state        <= MARK;
                            o_data_morse <= 1'b1;
                            elem_cnt     <= elem_cnt - 3'd1;
                            pat          <= {pat[3:0], 1'b0};
                            bit_left     <= pat[3] ? 3'd2 : 3'd0;
                        end else begin
                            state    <= TERM;
                            bit_left <= 3'd1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                TERM: begin
                    o_data_morse <= 1'b0;
                    if (term_fin) begin
                        state    <= IDLE;
                        o_done   <= 1'b1;
                        cyc_cnt  <= 8'd0;
                        bit_left <= 3'd0;
                    end else if (last_cyc) begin
                        cyc_cnt  <= 8'd0;
                        bit_left <= bit_left - 3'd1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
